ar_disp_seq: RTL

Parametrised display page sequencer for ARINC-style words (8-bit address, 23-bit data) from NCH receive/transmit channels. It snapshots each channel's latest word on a strobe, then steps a 16-bit display page through all channels, either automatically on a timer or manually on a step pulse. A freeze input holds the snapshots, and per-channel fresh flags mark words not yet shown. It sits between the channel cores and the 4-digit 7-segment driver.

---
 rtl/ar_pkg.sv | 25 ++
 rtl/ar_page_timer.sv | 33 +++
 rtl/ar_disp_seq.sv | 102 ++++++++++
 3 files changed

// File: rtl/ar_pkg.sv
// ar_pkg: shared widths and the display page formatter for the ARINC
// display sequencer.
//   ADR_W  : ARINC label/address width
//   DAT_W  : ARINC data field width
//   DISP_W : width of one display page (4 hex digits)
//   fmt_page() builds either the header page {adr, 0, dat[22:16]} or the
//   low page dat[15:0] of one channel.
package ar_pkg;

  localparam int ADR_W  = 8;
  localparam int DAT_W  = 23;
  localparam int DISP_W = 16;

  function automatic logic [DISP_W-1:0] fmt_page(
    input logic             low,
    input logic [ADR_W-1:0] adr,
    input logic [DAT_W-1:0] dat
  );
    logic [DISP_W-1:0] r;
    if (low) r = dat[15:0];
    else     r = {adr, 1'b0, dat[22:16]};
    return r;
  endfunction

endpackage

// File: rtl/ar_page_timer.sv
// ar_page_timer: free-running page period counter.
//   clk, rst_n : clock, async active-low reset
//   EN         : count enable; while low the count is held at 0
//   CLR        : synchronous clear to 0 (manual step restarts the period)
//   TICK       : one-cycle pulse while the count sits at PAGE_TICKS-1 and
//                EN is high; the count wraps to 0 on that edge
module ar_page_timer #(
  parameter int PAGE_TICKS = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int CW = $clog2(PAGE_TICKS);

  logic [CW-1:0] cnt_q;
  logic          term;

  assign term = (cnt_q == CW'(PAGE_TICKS - 1));
  assign TICK = EN & term;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt_q <= '0;
    else if (CLR || !EN || term) cnt_q <= '0;
    else                        cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/ar_disp_seq.sv
// ar_disp_seq: display page sequencer for NCH ARINC channels.
//   clk, rst_n : clock, async active-low reset
//   CH_ADR     : per-channel address, channel c at [8c+7:8c]
//   CH_DAT     : per-channel data, channel c at [23c+22:23c]
//   CH_STB     : per-channel capture strobe (one cycle)
//   AUTO       : level, timed page advance enabled
//   STEP       : one-cycle manual page advance (also restarts the period)
//   FREEZE     : level, strobes are dropped while high
//   DISPL      : registered contents of the current page
//   PAGE       : registered page index, 0..2*NCH-1
//   FRESH      : channel captured a word whose header page is not yet shown
module ar_disp_seq
  import ar_pkg::*;
#(
  parameter int  NCH        = 2,
  parameter int  PAGE_TICKS = 50_000_000,
  localparam int PW         = ($clog2(2 * NCH) < 1) ? 1 : $clog2(2 * NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*ADR_W-1:0] CH_ADR,
  input  logic [NCH*DAT_W-1:0] CH_DAT,
  input  logic [NCH-1:0]       CH_STB,
  input  logic                 AUTO,
  input  logic                 STEP,
  input  logic                 FREEZE,
  output logic [DISP_W-1:0]    DISPL,
  output logic [PW-1:0]        PAGE,
  output logic [NCH-1:0]       FRESH
);

  localparam int NP = 2 * NCH;

  logic [ADR_W-1:0]  adr_q [NCH];
  logic [DAT_W-1:0]  dat_q [NCH];
  logic [NCH-1:0]    cap;
  logic              tick;
  logic              advance;
  logic [NCH-1:0]    fresh_d;
  logic [DISP_W-1:0] displ_d;

  ar_page_timer #(.PAGE_TICKS(PAGE_TICKS)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .EN    (AUTO),
    .CLR   (STEP),
    .TICK  (tick)
  );

  // Step and timer expiry in the same cycle merge into a single advance.
  assign advance = STEP | tick;
  assign cap     = CH_STB & {NCH{~FREEZE}};

  // NOTE: the snapshot array is reset because its contents are visible on
  // DISPL straight after reset; a pure storage array would not need it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        adr_q[c] <= '0;
        dat_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (cap[c]) begin
          adr_q[c] <= CH_ADR[ADR_W*c +: ADR_W];
          dat_q[c] <= CH_DAT[DAT_W*c +: DAT_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       PAGE <= '0;
    else if (advance) PAGE <= (PAGE == PW'(NP - 1)) ? '0 : PAGE + PW'(1);
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    fresh_d = FRESH;
    displ_d = '0;
    for (int c = 0; c < NCH; c++) begin
      // A capture takes priority over the header-page clear.
      if (cap[c])                    fresh_d[c] = 1'b1;
      else if (PAGE == PW'(2 * c))   fresh_d[c] = 1'b0;

      if (PAGE == PW'(2 * c))     displ_d = fmt_page(1'b0, adr_q[c], dat_q[c]);
      if (PAGE == PW'(2 * c + 1)) displ_d = fmt_page(1'b1, adr_q[c], dat_q[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FRESH <= '0;
      DISPL <= '0;
    end else begin
      FRESH <= fresh_d;
      DISPL <= displ_d;
    end
  end

endmodule
